// File: rtl/pss_ssb_tracker.sv
// SSB timing tracker: acquires on a SEARCH detection, then alternates PAUSE and FIND windows around the expected PSS.
// Optional debug ports are enabled with the PSS_SSB_TRACKER_DEBUG_EN macro.
module pss_ssb_tracker #(
    parameter int  SSB_INTERVAL    = 38400,
    parameter int  TRACK_TOLERANCE = 100,
    parameter int  MAX_MISSES      = 3,
    localparam int CNT_DW          = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1),
    localparam int MISS_DW         = ($clog2(MAX_MISSES + 1) < 2) ? 2 : $clog2(MAX_MISSES + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     s_axis_in_tvalid,
    input  logic [1:0]               N_id_2_i,
    input  logic                     N_id_2_valid_i,
    output logic [1:0]               mode_o,
    output logic [1:0]               requested_N_id_2_o,
    output logic [1:0]               N_id_2_o,
    output logic                     locked_o,
    output logic                     ssb_start_o,
    output logic signed [CNT_DW:0]   timing_err_o,
    output logic [MISS_DW-1:0]       miss_cnt_o
`ifdef PSS_SSB_TRACKER_DEBUG_EN
    ,
    output logic [1:0]               debug_state_o,
    output logic [CNT_DW-1:0]        debug_sample_cnt_o
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_FIND   = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;

    localparam logic [CNT_DW-1:0]  CNT_FIND_OPEN = CNT_DW'(SSB_INTERVAL - TRACK_TOLERANCE - 1);
    localparam logic [CNT_DW-1:0]  CNT_TIMEOUT   = CNT_DW'(SSB_INTERVAL + TRACK_TOLERANCE - 1);
    localparam logic [CNT_DW-1:0]  CNT_FREEWHEEL = CNT_DW'(TRACK_TOLERANCE);
    localparam logic [CNT_DW:0]    SSB_EXT       = (CNT_DW + 1)'(SSB_INTERVAL);
    localparam logic [MISS_DW-1:0] MISS_LIMIT    = MISS_DW'(MAX_MISSES);

    logic [1:0]              r_state;
    logic [CNT_DW-1:0]       r_cnt;
    logic [1:0]              r_nid;
    logic                    r_locked;
    logic                    r_ssb_start;
    logic [CNT_DW:0]         r_err;
    logic [MISS_DW-1:0]      r_miss;

    logic [1:0]              w_state_nxt;
    logic [CNT_DW-1:0]       w_cnt_nxt;
    logic [1:0]              w_nid_nxt;
    logic                    w_locked_nxt;
    logic                    w_ssb_nxt;
    logic [CNT_DW:0]         w_err_nxt;
    logic [MISS_DW-1:0]      w_miss_nxt;

    logic [CNT_DW-1:0]       w_cnt_inc;
    logic [CNT_DW:0]         w_err_calc;
    logic [MISS_DW-1:0]      w_miss_inc;

    assign w_cnt_inc  = r_cnt + CNT_DW'(1);
    assign w_err_calc = {1'b0, r_cnt} - SSB_EXT;
    assign w_miss_inc = r_miss + MISS_DW'(1);

    // The counter is held in SEARCH so it never runs past the window end while unused.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_nid_nxt    = r_nid;
        w_locked_nxt = r_locked;
        w_ssb_nxt    = 1'b0;
        w_err_nxt    = r_err;
        w_miss_nxt   = r_miss;
        case (r_state)
            ST_SEARCH: begin
                if (N_id_2_valid_i) begin
                    w_nid_nxt   = N_id_2_i;
                    w_cnt_nxt   = '0;
                    w_ssb_nxt   = 1'b1;
                    w_miss_nxt  = '0;
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (s_axis_in_tvalid) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == CNT_FIND_OPEN) begin
                        w_state_nxt = ST_FIND;
                    end
                end
            end
            ST_FIND: begin
                if (N_id_2_valid_i) begin
                    w_err_nxt    = w_err_calc;
                    w_cnt_nxt    = '0;
                    w_miss_nxt   = '0;
                    w_locked_nxt = 1'b1;
                    w_ssb_nxt    = 1'b1;
                    w_state_nxt  = ST_PAUSE;
                end else if (s_axis_in_tvalid) begin
                    if (r_cnt == CNT_TIMEOUT) begin
                        if (w_miss_inc == MISS_LIMIT) begin
                            w_state_nxt  = ST_SEARCH;
                            w_locked_nxt = 1'b0;
                            w_miss_nxt   = '0;
                            w_cnt_nxt    = '0;
                        end else begin
                            // Nominal PSS position lies TRACK_TOLERANCE samples behind the window end.
                            w_miss_nxt  = w_miss_inc;
                            w_cnt_nxt   = CNT_FREEWHEEL;
                            w_state_nxt = ST_PAUSE;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_SEARCH;
            r_cnt       <= '0;
            r_nid       <= '0;
            r_locked    <= 1'b0;
            r_ssb_start <= 1'b0;
            r_err       <= '0;
            r_miss      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nid       <= w_nid_nxt;
            r_locked    <= w_locked_nxt;
            r_ssb_start <= w_ssb_nxt;
            r_err       <= w_err_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    assign mode_o             = r_state;
    assign requested_N_id_2_o = r_nid;
    assign N_id_2_o           = r_nid;
    assign locked_o           = r_locked;
    assign ssb_start_o        = r_ssb_start;
    assign timing_err_o       = $signed(r_err);
    assign miss_cnt_o         = r_miss;

`ifdef PSS_SSB_TRACKER_DEBUG_EN
    assign debug_state_o      = r_state;
    assign debug_sample_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_pss_ssb_tracker.sv
// Directed bench for pss_ssb_tracker with a window-based reference model checked every cycle.
module tb_pss_ssb_tracker;

    localparam int SSB    = 1000;
    localparam int TOL    = 10;
    localparam int MAXM   = 3;
    localparam int CNT_DW = $clog2(SSB + TOL + 1);
    localparam int MISS_DW = ($clog2(MAXM + 1) < 2) ? 2 : $clog2(MAXM + 1);

    logic                   clock;
    logic                   reset;
    logic                   tvalid;
    logic [1:0]             nidIn;
    logic                   nidValid;
    logic [1:0]             mode;
    logic [1:0]             reqNid;
    logic [1:0]             nidOut;
    logic                   locked;
    logic                   ssbStart;
    logic signed [CNT_DW:0] timingErr;
    logic [MISS_DW-1:0]     missCnt;
`ifdef PSS_SSB_TRACKER_DEBUG_EN
    logic [1:0]             dbgState;
    logic [CNT_DW-1:0]      dbgCnt;
`endif

    int checks = 0;
    int errors = 0;
    int ssbPulses = 0;

    pss_ssb_tracker #(
        .SSB_INTERVAL   (SSB),
        .TRACK_TOLERANCE(TOL),
        .MAX_MISSES     (MAXM)
    ) dut (
        .clk_i             (clock),
        .reset_i           (reset),
        .s_axis_in_tvalid  (tvalid),
        .N_id_2_i          (nidIn),
        .N_id_2_valid_i    (nidValid),
        .mode_o            (mode),
        .requested_N_id_2_o(reqNid),
        .N_id_2_o          (nidOut),
        .locked_o          (locked),
        .ssb_start_o       (ssbStart),
        .timing_err_o      (timingErr),
        .miss_cnt_o        (missCnt)
`ifdef PSS_SSB_TRACKER_DEBUG_EN
        ,
        .debug_state_o     (dbgState),
        .debug_sample_cnt_o(dbgCnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: samples elapsed since the last reference point decide whether the window is open.
    bit mAcq    = 1'b0;
    int mCnt    = 0;
    int mNid    = 0;
    int mLocked = 0;
    int mSsb    = 0;
    int mErr    = 0;
    int mMiss   = 0;

    function automatic int modelMode();
        if (!mAcq) return 0;
        return (mCnt >= SSB - TOL) ? 1 : 2;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mAcq = 1'b0; mCnt = 0; mNid = 0; mLocked = 0; mSsb = 0; mErr = 0; mMiss = 0;
        end else begin
            mSsb = 0;
            if (!mAcq) begin
                if (nidValid) begin
                    mAcq = 1'b1; mNid = nidIn; mCnt = 0; mSsb = 1; mMiss = 0;
                end
            end else if (nidValid && modelMode() == 1) begin
                mErr = mCnt - SSB; mCnt = 0; mMiss = 0; mLocked = 1; mSsb = 1;
            end else if (tvalid) begin
                if (mCnt + 1 >= SSB + TOL) begin
                    mMiss = mMiss + 1;
                    if (mMiss == MAXM) begin
                        mAcq = 1'b0; mLocked = 0; mMiss = 0; mCnt = 0;
                    end else begin
                        mCnt = (SSB + TOL) - SSB;
                    end
                end else begin
                    mCnt = mCnt + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("cmp mode", int'(mode), modelMode());
            checkOutput("cmp requested_N_id_2", int'(reqNid), mNid);
            checkOutput("cmp N_id_2", int'(nidOut), mNid);
            checkOutput("cmp locked", int'(locked), mLocked);
            checkOutput("cmp ssb_start", int'(ssbStart), mSsb);
            checkOutput("cmp timing_err", int'(timingErr), mErr);
            checkOutput("cmp miss_cnt", int'(missCnt), mMiss);
        end
    end

    task automatic applyStimulus(input logic tv, input logic v, input logic [1:0] nid);
        tvalid   = tv;
        nidValid = v;
        nidIn    = nid;
        @(negedge clock);
        if (ssbStart) ssbPulses++;
    endtask

    task automatic runSamples(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'd0);
    endtask

    task automatic runHalf(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
            applyStimulus(1'b1, 1'b0, 2'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        tvalid   = 1'b0;
        nidValid = 1'b0;
        nidIn    = 2'd0;
        repeat (3) @(negedge clock);
        checkOutput("reset mode", int'(mode), 0);
        checkOutput("reset locked", int'(locked), 0);
        reset = 1'b0;

        $display("[TB] test 1: idle search");
        runSamples(5000);
        checkOutput("t1 mode", int'(mode), 0);
        checkOutput("t1 locked", int'(locked), 0);
        checkOutput("t1 ssb pulses", ssbPulses, 0);

        $display("[TB] test 2: acquire and first hit");
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t2 mode pause", int'(mode), 2);
        checkOutput("t2 requested", int'(reqNid), 2);
        runSamples(989);
        checkOutput("t2 mode before find", int'(mode), 2);
        runSamples(1);
        checkOutput("t2 mode find", int'(mode), 1);
        runSamples(10);
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t2 locked", int'(locked), 1);
        checkOutput("t2 timing_err", int'(timingErr), 0);
        checkOutput("t2 ssb pulses", ssbPulses, 2);

        $display("[TB] test 3: timing error sign and early pulse");
        runSamples(1007);
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t3 err late", int'(timingErr), 7);
        runSamples(993);
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t3 err early", int'(timingErr), -7);
        runSamples(985);
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t3 ignored mode", int'(mode), 2);
        checkOutput("t3 ignored err", int'(timingErr), -7);
        checkOutput("t3 ignored ssb", ssbPulses, 4);
        runSamples(14);
        applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("t3 err resync", int'(timingErr), 0);
        checkOutput("t3 ssb pulses", ssbPulses, 5);

        $display("[TB] test 4: misses and fallback");
        runSamples(1010);
        checkOutput("t4 miss1", int'(missCnt), 1);
        checkOutput("t4 miss1 mode", int'(mode), 2);
        checkOutput("t4 miss1 locked", int'(locked), 1);
        runSamples(979);
        checkOutput("t4 freewheel pause", int'(mode), 2);
        runSamples(1);
        checkOutput("t4 freewheel find", int'(mode), 1);
        runSamples(20);
        checkOutput("t4 miss2", int'(missCnt), 2);
        runSamples(1000);
        checkOutput("t4 fallback mode", int'(mode), 0);
        checkOutput("t4 fallback locked", int'(locked), 0);
        checkOutput("t4 fallback miss", int'(missCnt), 0);

        $display("[TB] test 5: half duty tvalid");
        applyStimulus(1'b1, 1'b1, 2'd1);
        runHalf(989);
        checkOutput("t5 pause after 989 samples", int'(mode), 2);
        runHalf(1);
        checkOutput("t5 find after 990 samples", int'(mode), 1);
        runHalf(5);
        applyStimulus(1'b0, 1'b1, 2'd1);
        checkOutput("t5 err", int'(timingErr), -5);
        checkOutput("t5 ssb pulses", ssbPulses, 7);

        $display("[TB] test 6: async reset mid-find and hit on timeout sample");
        runSamples(995);
        checkOutput("t6 in find", int'(mode), 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6 reset mode", int'(mode), 0);
        checkOutput("t6 reset locked", int'(locked), 0);
        checkOutput("t6 reset err", int'(timingErr), 0);
        checkOutput("t6 reset nid", int'(nidOut), 0);
        checkOutput("t6 reset ssb", int'(ssbStart), 0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd3);
        runSamples(1009);
        checkOutput("t6 find at edge", int'(mode), 1);
        applyStimulus(1'b1, 1'b1, 2'd0);
        checkOutput("t6 hit err", int'(timingErr), 9);
        checkOutput("t6 hit locked", int'(locked), 1);
        checkOutput("t6 hit miss", int'(missCnt), 0);
        checkOutput("t6 hit nid kept", int'(nidOut), 3);
        checkOutput("t6 ssb pulses", ssbPulses, 9);
        runSamples(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
